psum_packetizer: RTL and testbench

- Downstream neighbour of the PE split stage: consumes the final partial sums the split stage emits on its packet output and wraps them into NoC packets for the router.
- Collects NPSUM psums, then emits one header flit followed by NPSUM payload flits.
- Clocked RTL with valid/ready handshakes. A CSP-to-valid/ready shim drives the input side.

---
 rtl/pkt_pkg.sv | 27 ++
 rtl/psum_collect_buf.sv | 42 ++++
 rtl/psum_packetizer.sv | 128 ++++++++++++
 tb/tb_psum_packetizer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pkt_pkg.sv
// Shared types and header layout for the psum packetizer.
// The header occupies the low 16 bits of every flit; wider flits pad with zeros.
package pkt_pkg;

  typedef enum logic [1:0] {COLLECT, HEADER, PAYLOAD} state_t;

  localparam int HDR_W    = 16;
  localparam int FIELD_W  = 4;
  localparam int DEST_MSB = 15;
  localparam int SRC_MSB  = 11;
  localparam int SEQ_MSB  = 7;
  localparam int CNT_MSB  = 3;

  typedef logic [HDR_W-1:0] flit_t;

  function automatic flit_t make_header(input logic [3:0] dest, input logic [3:0] src,
                                        input logic [3:0] seq, input logic [3:0] cnt);
    flit_t h;
    h = '0;
    h[DEST_MSB -: FIELD_W] = dest;
    h[SRC_MSB  -: FIELD_W] = src;
    h[SEQ_MSB  -: FIELD_W] = seq;
    h[CNT_MSB  -: FIELD_W] = cnt;
    return h;
  endfunction

endpackage

// File: rtl/psum_collect_buf.sv
// NPSUM-entry payload register file: indexed write, combinational indexed read.
// Out-of-range read indices return zero so the look-ahead read past the tail is harmless.
module psum_collect_buf #(
  parameter int DWIDTH = 8,
  parameter int NPSUM  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [3:0]        wr_idx,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic [3:0]        rd_idx,
  output logic [DWIDTH-1:0] rd_data
);

  logic [DWIDTH-1:0] mem_reg [NPSUM];
  logic [NPSUM-1:0]  wr_sel;

  generate
    for (genvar gi = 0; gi < NPSUM; gi++) begin : g_sel
      assign wr_sel[gi] = wr_en && (wr_idx == 4'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < NPSUM; i++) begin
      if (rst) begin
        mem_reg[i] <= '0;
      end else if (wr_sel[i]) begin
        mem_reg[i] <= wr_data;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NPSUM; i++) begin
      if (rd_idx == 4'(i)) rd_data = mem_reg[i];
    end
  end

endmodule

// File: rtl/psum_packetizer.sv
// Collects NPSUM partial sums and emits them as one header flit plus NPSUM payload flits.
// All handshake outputs are registered, so neither side sees a combinational path from the other.
module psum_packetizer
  import pkt_pkg::*;
#(
  parameter int         DWIDTH  = 8,
  parameter int         FWIDTH  = 16,
  parameter int         NPSUM   = 2,
  parameter logic [3:0] SRC_ID  = 4'd0,
  parameter logic [3:0] DEST_ID = 4'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] psum_data,
  input  logic              psum_valid,
  output logic              psum_ready,
  output logic [FWIDTH-1:0] flit_data,
  output logic              flit_valid,
  input  logic              flit_ready,
  output logic              flit_last,
  output logic [7:0]        pkt_sent
);

  localparam logic [3:0] LAST_IDX = 4'(NPSUM - 1);
  localparam logic [3:0] NPSUM_F  = 4'(NPSUM);

  state_t            state_reg;
  logic [3:0]        cnt_reg;
  logic [3:0]        seq_reg;
  logic [7:0]        pkt_sent_reg;
  logic [FWIDTH-1:0] flit_data_reg;
  logic              flit_valid_reg;
  logic              flit_last_reg;
  logic              psum_ready_reg;

  logic              psum_xfer;
  logic              flit_xfer;
  logic [3:0]        rd_idx;
  logic [DWIDTH-1:0] rd_data;

  assign psum_xfer = (state_reg == COLLECT) && psum_valid && psum_ready_reg;
  assign flit_xfer = flit_valid_reg && flit_ready;

  // flit_data is registered, so the buffer is read one entry ahead of the flit on the wire.
  assign rd_idx = (state_reg == HEADER) ? 4'd0 : 4'(cnt_reg + 4'd1);

  psum_collect_buf #(
    .DWIDTH(DWIDTH),
    .NPSUM (NPSUM)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (psum_xfer),
    .wr_idx (cnt_reg),
    .wr_data(psum_data),
    .rd_idx (rd_idx),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= COLLECT;
      cnt_reg        <= '0;
      seq_reg        <= '0;
      pkt_sent_reg   <= '0;
      flit_data_reg  <= '0;
      flit_valid_reg <= 1'b0;
      flit_last_reg  <= 1'b0;
      psum_ready_reg <= 1'b1;
    end else begin
      case (state_reg)
        COLLECT: begin
          if (psum_xfer) begin
            if (cnt_reg == LAST_IDX) begin
              state_reg      <= HEADER;
              cnt_reg        <= '0;
              psum_ready_reg <= 1'b0;
              flit_valid_reg <= 1'b1;
              flit_last_reg  <= 1'b0;
              flit_data_reg  <= FWIDTH'(make_header(DEST_ID, SRC_ID, seq_reg, NPSUM_F));
            end else begin
              cnt_reg <= cnt_reg + 4'd1;
            end
          end
        end
        HEADER: begin
          if (flit_xfer) begin
            state_reg     <= PAYLOAD;
            flit_data_reg <= FWIDTH'(rd_data);
            flit_last_reg <= (LAST_IDX == 4'd0);
          end
        end
        PAYLOAD: begin
          if (flit_xfer) begin
            if (cnt_reg == LAST_IDX) begin
              state_reg      <= COLLECT;
              cnt_reg        <= '0;
              seq_reg        <= seq_reg + 4'd1;
              pkt_sent_reg   <= pkt_sent_reg + 8'd1;
              flit_data_reg  <= '0;
              flit_valid_reg <= 1'b0;
              flit_last_reg  <= 1'b0;
              psum_ready_reg <= 1'b1;
            end else begin
              cnt_reg       <= cnt_reg + 4'd1;
              flit_data_reg <= FWIDTH'(rd_data);
              flit_last_reg <= ((cnt_reg + 4'd1) == LAST_IDX);
            end
          end
        end
        default: begin
          state_reg      <= COLLECT;
          cnt_reg        <= '0;
          flit_valid_reg <= 1'b0;
          flit_last_reg  <= 1'b0;
          psum_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign psum_ready = psum_ready_reg;
  assign flit_data  = flit_data_reg;
  assign flit_valid = flit_valid_reg;
  assign flit_last  = flit_last_reg;
  assign pkt_sent   = pkt_sent_reg;

endmodule

// File: tb/tb_psum_packetizer.sv
// Randomized scoreboard bench: the driver builds expected packets from accepted psums,
// the monitor pops and compares every flit the router accepts.
module tb_psum_packetizer;

  localparam int         DWIDTH  = 8;
  localparam int         FWIDTH  = 16;
  localparam int         NPSUM   = 2;
  localparam logic [3:0] SRC_ID  = 4'd5;
  localparam logic [3:0] DEST_ID = 4'd3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DWIDTH-1:0] psum_data = '0;
  logic              psum_valid = 1'b0;
  logic              psum_ready;
  logic [FWIDTH-1:0] flit_data;
  logic              flit_valid;
  logic              flit_ready = 1'b0;
  logic              flit_last;
  logic [7:0]        pkt_sent;

  psum_packetizer #(
    .DWIDTH (DWIDTH),
    .FWIDTH (FWIDTH),
    .NPSUM  (NPSUM),
    .SRC_ID (SRC_ID),
    .DEST_ID(DEST_ID)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .psum_data (psum_data),
    .psum_valid(psum_valid),
    .psum_ready(psum_ready),
    .flit_data (flit_data),
    .flit_valid(flit_valid),
    .flit_ready(flit_ready),
    .flit_last (flit_last),
    .pkt_sent  (pkt_sent)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model state: partial packet, expected flits {last, data}, sequence and packet counts.
  logic [DWIDTH-1:0] part_q[$];
  logic [16:0]       exp_q[$];
  int                model_seq  = 0;
  int                model_pkts = 0;
  bit                busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h expected=%h @%0t", name, got, exp, $time);
  endtask

  task automatic model_accept(input logic [DWIDTH-1:0] d);
    part_q.push_back(d);
    if (part_q.size() == NPSUM) begin
      exp_q.push_back({1'b0, DEST_ID, SRC_ID, 4'(model_seq), 4'(NPSUM)});
      for (int i = 0; i < NPSUM; i++)
        exp_q.push_back({(i == NPSUM - 1), 8'h00, part_q[i]});
      model_seq = (model_seq + 1) % 16;
      part_q.delete();
      busy = 1'b1;
    end
  endtask

  task automatic model_reset();
    part_q.delete();
    exp_q.delete();
    model_seq  = 0;
    model_pkts = 0;
    busy       = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    rst = 1'b1; psum_valid = 1'b0; flit_ready = 1'b0;
    model_reset();
    repeat (cycles - 1) @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One clock: drive after the rising edge, record the input transfer after the falling edge.
  task automatic step(input logic v, input logic [DWIDTH-1:0] d, input logic fr);
    @(posedge clk); #1;
    psum_valid = v; psum_data = d; flit_ready = fr;
    @(negedge clk); #1;
    if (psum_valid && psum_ready && !rst) model_accept(psum_data);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step(1'b0, '0, 1'b1);
      n++;
    end
    if (busy) chk("drain_timeout", 32'(busy), 32'd0);
  endtask

  // Monitor: handshake seen on the falling edge transfers on the next rising edge.
  logic [16:0] held_flit;
  bit          held = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      chk("psum_ready", 32'(psum_ready), 32'(!busy));
      chk("flit_valid", 32'(flit_valid), 32'(busy));
      chk("pkt_sent", 32'(pkt_sent), 32'(model_pkts % 256));
      if (held) begin
        chk("hold_valid", 32'(flit_valid), 32'd1);
        chk("hold_flit", 32'({flit_last, flit_data}), 32'(held_flit));
      end
      held = 1'b0;
      if (flit_valid && !flit_ready) begin
        held = 1'b1;
        held_flit = {flit_last, flit_data};
      end
      if (flit_valid && flit_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_flit", 32'({flit_last, flit_data}), 32'h1ffff);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          $display("flit data=%h last=%0b expected data=%h last=%0b", flit_data, flit_last,
                   e[15:0], e[16]);
          chk("flit", 32'({flit_last, flit_data}), 32'(e));
          if (e[16]) begin
            model_pkts++;
            busy = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset(3);
    @(negedge clk); #2;
    chk("rst_psum_ready", 32'(psum_ready), 32'd1);
    chk("rst_flit_valid", 32'(flit_valid), 32'd0);
    chk("rst_flit_last", 32'(flit_last), 32'd0);
    chk("rst_flit_data", 32'(flit_data), 32'd0);
    chk("rst_pkt_sent", 32'(pkt_sent), 32'd0);

    // Basic packet: expect 0x3502, 0x0012, 0x0034.
    step(1'b1, 8'h12, 1'b1);
    step(1'b1, 8'h34, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    drain(20);
    @(negedge clk); #2;
    chk("basic_pkt_sent", 32'(pkt_sent), 32'd1);

    // Backpressure on the header for three cycles.
    step(1'b1, 8'h12, 1'b0);
    step(1'b1, 8'h34, 1'b0);
    repeat (3) step(1'b1, 8'h77, 1'b0);
    drain(20);

    // Random traffic, enough packets to wrap the 4-bit sequence.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0);
    drain(40);
    @(negedge clk); #2;
    chk("wrap_pkt_sent", 32'(pkt_sent), 32'(model_pkts % 256));

    // Reset after the header is accepted, before any payload leaves.
    step(1'b1, 8'h55, 1'b0);
    step(1'b1, 8'h66, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    do_reset(1);
    @(negedge clk); #2;
    chk("midrst_flit_valid", 32'(flit_valid), 32'd0);
    chk("midrst_pkt_sent", 32'(pkt_sent), 32'd0);
    step(1'b1, 8'hA1, 1'b1);
    step(1'b1, 8'hA2, 1'b1);
    drain(20);

    // Input pressure: psum_valid held high with a fresh value every cycle.
    for (int i = 0; i < 24; i++)
      step(1'b1, 8'(8'hC0 + i), $urandom_range(0, 4) != 0);
    step(1'b0, 8'h00, 1'b1);
    drain(40);

    @(negedge clk); #2;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
